// File: rtl/bus_pkg.sv
// Shared slot definitions for the system bus time-slot scheduler.
// Slot enum, slot start cycles, frame length helper and decoder bundle.
package bus_pkg;

    localparam int CYC_W = 5;

    typedef enum logic [2:0] {
        SLOT_SPI_A,
        SLOT_VRAM0,
        SLOT_VROM0,
        SLOT_SPI_B,
        SLOT_VRAM1,
        SLOT_VROM1,
        SLOT_CPU
    } slot_e;

    localparam logic [CYC_W-1:0] START_SPI_A = 5'd0;
    localparam logic [CYC_W-1:0] START_VRAM0 = 5'd2;
    localparam logic [CYC_W-1:0] START_VROM0 = 5'd4;
    localparam logic [CYC_W-1:0] START_SPI_B = 5'd6;
    localparam logic [CYC_W-1:0] START_VRAM1 = 5'd8;
    localparam logic [CYC_W-1:0] START_VROM1 = 5'd10;
    localparam logic [CYC_W-1:0] START_CPU   = 5'd12;

    typedef struct packed {
        slot_e slot;
        logic  setup;
        logic  strobe;
        logic  spi_cap;
    } slot_info_t;

    function automatic int frame_len(input int cpu_cycles);
        return 12 + cpu_cycles;
    endfunction

endpackage

// File: rtl/slot_decoder.sv
// Maps a frame cycle and the latched video enable to slot, phase
// and SPI-capable flag. Purely combinational.
module slot_decoder
    import bus_pkg::*;
#(
    parameter int CPU_CYCLES    = 4,
    parameter bit RECLAIM_VIDEO = 1'b1
) (
    input  logic [CYC_W-1:0] i_cyc,
    input  logic             i_video_en,
    output slot_info_t       o_info
);

    localparam logic [CYC_W-1:0] LAST =
        CYC_W'(frame_len(CPU_CYCLES) - 1);

    slot_e w_slot;

    always_comb begin
        if (i_cyc >= START_CPU)
            w_slot = SLOT_CPU;
        else if (i_cyc >= START_VROM1)
            w_slot = SLOT_VROM1;
        else if (i_cyc >= START_VRAM1)
            w_slot = SLOT_VRAM1;
        else if (i_cyc >= START_SPI_B)
            w_slot = SLOT_SPI_B;
        else if (i_cyc >= START_VROM0)
            w_slot = SLOT_VROM0;
        else if (i_cyc >= START_VRAM0)
            w_slot = SLOT_VRAM0;
        else
            w_slot = SLOT_SPI_A;
    end

    always_comb begin
        o_info      = '0;
        o_info.slot = w_slot;
        // Two-cycle slots below the CPU slot; CPU slot spans the rest
        if (i_cyc < START_CPU) begin
            o_info.setup  = ~i_cyc[0];
            o_info.strobe = i_cyc[0];
        end else begin
            o_info.setup  = (i_cyc == START_CPU);
            o_info.strobe = (i_cyc == LAST);
        end
        unique case (w_slot)
            SLOT_SPI_A, SLOT_SPI_B: o_info.spi_cap = 1'b1;
            SLOT_CPU:               o_info.spi_cap = 1'b0;
            default: o_info.spi_cap = RECLAIM_VIDEO && !i_video_en;
        endcase
    end

endmodule

// File: rtl/bus_scheduler.sv
// Time-slot scheduler for the shared system bus: frame counter,
// SPI grant with back-to-back blocking, registered slot enables.
module bus_scheduler
    import bus_pkg::*;
#(
    parameter int CPU_CYCLES    = 4,
    parameter bit RECLAIM_VIDEO = 1'b1
) (
    input  logic       clk16_i,
    input  logic       reset_i,
    input  logic       video_en_i,
    input  logic       spi_valid_i,
    output logic       spi_ready_o,
    output logic       spi_en_o,
    output logic       cpu_en_o,
    output logic       cpu_clk_o,
    output logic       cpu_be_o,
    output logic       vram0_en_o,
    output logic       vrom0_en_o,
    output logic       vram1_en_o,
    output logic       vrom1_en_o,
    output logic       setup_clk_o,
    output logic       strobe_clk_o,
    output logic [3:0] cycle_o
);

    localparam int FRAME = frame_len(CPU_CYCLES);
    localparam logic [CYC_W-1:0] LAST = CYC_W'(FRAME - 1);

    logic [CYC_W-1:0] r_cyc;
    logic [CYC_W-1:0] w_cyc_nxt;
    logic             r_vid;
    logic             w_vid_nxt;
    logic             r_grant;
    logic             w_grant_nxt;
    logic             r_ready;
    logic             r_cpu;
    logic             r_vram0;
    logic             r_vrom0;
    logic             r_vram1;
    logic             r_vrom1;
    logic             r_setup;
    logic             r_strobe;
    slot_info_t       w_info;

    assign w_cyc_nxt = (r_cyc == LAST) ? '0 : r_cyc + CYC_W'(1);
    assign w_vid_nxt = (w_cyc_nxt == '0) ? video_en_i : r_vid;

    // Outputs are computed for the cycle being entered
    slot_decoder #(
        .CPU_CYCLES    (CPU_CYCLES),
        .RECLAIM_VIDEO (RECLAIM_VIDEO)
    ) u_dec (
        .i_cyc      (w_cyc_nxt),
        .i_video_en (w_vid_nxt),
        .o_info     (w_info)
    );

    always_comb begin
        w_grant_nxt = r_grant;
        if (w_info.setup)
            w_grant_nxt = w_info.spi_cap && spi_valid_i && !r_grant;
    end

    always_ff @(posedge clk16_i) begin
        if (reset_i) begin
            r_cyc    <= LAST;
            r_vid    <= 1'b0;
            r_grant  <= 1'b0;
            r_ready  <= 1'b0;
            r_cpu    <= 1'b0;
            r_vram0  <= 1'b0;
            r_vrom0  <= 1'b0;
            r_vram1  <= 1'b0;
            r_vrom1  <= 1'b0;
            r_setup  <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_cyc    <= w_cyc_nxt;
            r_vid    <= w_vid_nxt;
            r_grant  <= w_grant_nxt;
            r_ready  <= w_grant_nxt && w_info.strobe;
            r_cpu    <= (w_info.slot == SLOT_CPU);
            r_vram0  <= w_vid_nxt && (w_info.slot == SLOT_VRAM0);
            r_vrom0  <= w_vid_nxt && (w_info.slot == SLOT_VROM0);
            r_vram1  <= w_vid_nxt && (w_info.slot == SLOT_VRAM1);
            r_vrom1  <= w_vid_nxt && (w_info.slot == SLOT_VROM1);
            r_setup  <= w_info.setup;
            r_strobe <= w_info.strobe;
        end
    end

    assign spi_en_o     = r_grant;
    assign spi_ready_o  = r_ready;
    assign cpu_en_o     = r_cpu;
    assign cpu_clk_o    = r_cpu;
    assign cpu_be_o     = r_cpu;
    assign vram0_en_o   = r_vram0;
    assign vrom0_en_o   = r_vrom0;
    assign vram1_en_o   = r_vram1;
    assign vrom1_en_o   = r_vrom1;
    assign setup_clk_o  = r_setup;
    assign strobe_clk_o = r_strobe;
    // Debug view only; frames longer than 16 cycles alias here
    assign cycle_o      = r_cyc[3:0];

endmodule

// File: tb/tb_bus_scheduler.sv
// Self-checking bench for bus_scheduler: per-frame vector table plus
// hand sequences for reset mid-grant and an 18-cycle frame variant.
module tb_bus_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       vid;
    logic       valid;
    logic       spi_ready, spi_en, cpu_en, cpu_clk, cpu_be;
    logic       vram0, vrom0, vram1, vrom1, setup, strobe;
    logic [3:0] cyc;

    logic       rst6;
    logic       vid6 = 1'b1;
    logic       valid6 = 1'b0;
    logic       spi_ready6, spi_en6, cpu_en6, cpu_clk6, cpu_be6;
    logic       vram06, vrom06, vram16, vrom16, setup6, strobe6;
    logic [3:0] cyc6;

    always #5 clk = ~clk;

    bus_scheduler #(.CPU_CYCLES(4), .RECLAIM_VIDEO(1'b1)) dut (
        .clk16_i      (clk),
        .reset_i      (rst),
        .video_en_i   (vid),
        .spi_valid_i  (valid),
        .spi_ready_o  (spi_ready),
        .spi_en_o     (spi_en),
        .cpu_en_o     (cpu_en),
        .cpu_clk_o    (cpu_clk),
        .cpu_be_o     (cpu_be),
        .vram0_en_o   (vram0),
        .vrom0_en_o   (vrom0),
        .vram1_en_o   (vram1),
        .vrom1_en_o   (vrom1),
        .setup_clk_o  (setup),
        .strobe_clk_o (strobe),
        .cycle_o      (cyc)
    );

    bus_scheduler #(.CPU_CYCLES(6), .RECLAIM_VIDEO(1'b1)) dut6 (
        .clk16_i      (clk),
        .reset_i      (rst6),
        .video_en_i   (vid6),
        .spi_valid_i  (valid6),
        .spi_ready_o  (spi_ready6),
        .spi_en_o     (spi_en6),
        .cpu_en_o     (cpu_en6),
        .cpu_clk_o    (cpu_clk6),
        .cpu_be_o     (cpu_be6),
        .vram0_en_o   (vram06),
        .vrom0_en_o   (vrom06),
        .vram1_en_o   (vram16),
        .vrom1_en_o   (vrom16),
        .setup_clk_o  (setup6),
        .strobe_clk_o (strobe6),
        .cycle_o      (cyc6)
    );

    typedef struct {
        string       nm;
        logic        pre_vid;
        logic        pre_valid;
        logic [15:0] vid_m;
        logic [15:0] val_m;
        logic [15:0] spi_m;
        logic [15:0] rdy_m;
        logic [15:0] vr0_m;
        logic [15:0] vo0_m;
        logic [15:0] vr1_m;
        logic [15:0] vo1_m;
    } row_t;

    localparam int NROWS = 7;
    row_t rows [NROWS];

    logic [15:0] setup_m  = 16'h1555;
    logic [15:0] strobe_m = 16'h8AAA;
    logic [15:0] cpu_m    = 16'hF000;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input int c,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, c, act, exp);
    endtask

    task automatic check_cyc(input string nm, input int i,
                             input logic e_spi, input logic e_rdy,
                             input logic e_vr0, input logic e_vo0,
                             input logic e_vr1, input logic e_vo1);
        chk({nm, ".cyc"}, i, 32'(cyc), i);
        chk({nm, ".spi_en"}, i, 32'(spi_en), 32'(e_spi));
        chk({nm, ".ready"}, i, 32'(spi_ready), 32'(e_rdy));
        chk({nm, ".video"}, i, 32'({vram0, vrom0, vram1, vrom1}),
            32'({e_vr0, e_vo0, e_vr1, e_vo1}));
        chk({nm, ".cpu"}, i, 32'({cpu_en, cpu_clk, cpu_be}),
            32'({3{cpu_m[i]}}));
        chk({nm, ".setup"}, i, 32'(setup), 32'(setup_m[i]));
        chk({nm, ".strobe"}, i, 32'(strobe), 32'(strobe_m[i]));
        chk({nm, ".onehot"}, i,
            32'($onehot0({spi_en, cpu_en, vram0, vrom0, vram1, vrom1})),
            32'd1);
    endtask

    initial begin
        rows[0] = '{"idle_vid", 1'b1, 1'b0, 16'hFFFF, 16'h0000,
                    16'h0000, 16'h0000,
                    16'h000C, 16'h0030, 16'h0300, 16'h0C00};
        rows[1] = '{"spi_vid", 1'b1, 1'b1, 16'hFFFF, 16'hFFFF,
                    16'h00C3, 16'h0082,
                    16'h000C, 16'h0030, 16'h0300, 16'h0C00};
        rows[2] = '{"spi_reclaim", 1'b0, 1'b1, 16'h0000, 16'hFFFF,
                    16'h0333, 16'h0222,
                    16'h0000, 16'h0000, 16'h0000, 16'h0000};
        rows[3] = '{"vid_drop_mid", 1'b1, 1'b0, 16'h001F, 16'h0000,
                    16'h0000, 16'h0000,
                    16'h000C, 16'h0030, 16'h0300, 16'h0C00};
        rows[4] = '{"vid_off_next", 1'b0, 1'b0, 16'h0000, 16'h0000,
                    16'h0000, 16'h0000,
                    16'h0000, 16'h0000, 16'h0000, 16'h0000};
        rows[5] = '{"valid_at_2", 1'b1, 1'b0, 16'hFFFF, 16'h00FC,
                    16'h00C0, 16'h0080,
                    16'h000C, 16'h0030, 16'h0300, 16'h0C00};
        rows[6] = '{"valid_gone", 1'b1, 1'b0, 16'hFFFF, 16'h0000,
                    16'h0000, 16'h0000,
                    16'h000C, 16'h0030, 16'h0300, 16'h0C00};

        rst   = 1'b1;
        rst6  = 1'b1;
        vid   = 1'b1;
        valid = 1'b0;

        repeat (3) begin
            @(posedge clk); #1;
            chk("rst.outs", -1,
                32'({spi_ready, spi_en, cpu_en, cpu_clk, cpu_be,
                     vram0, vrom0, vram1, vrom1, setup, strobe}), 32'd0);
            chk("rst.cyc", -1, 32'(cyc), 32'd15);
        end

        vid   = rows[0].pre_vid;
        valid = rows[0].pre_valid;
        rst   = 1'b0;

        for (int r = 0; r < NROWS; r++) begin
            for (int i = 0; i < 16; i++) begin
                @(posedge clk); #1;
                check_cyc(rows[r].nm, i,
                          rows[r].spi_m[i], rows[r].rdy_m[i],
                          rows[r].vr0_m[i], rows[r].vo0_m[i],
                          rows[r].vr1_m[i], rows[r].vo1_m[i]);
                if (i < 15) begin
                    vid   = rows[r].vid_m[i];
                    valid = rows[r].val_m[i];
                end else if (r < NROWS - 1) begin
                    vid   = rows[r+1].pre_vid;
                    valid = rows[r+1].pre_valid;
                end else begin
                    vid   = 1'b1;
                    valid = 1'b1;
                end
            end
        end

        // Reset lands on cycle 0 of a granted SPI_A slot
        @(posedge clk); #1;
        chk("abort.grant", 0, 32'(spi_en), 32'd1);
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("abort.ready", -1, 32'(spi_ready), 32'd0);
            chk("abort.spi", -1, 32'(spi_en), 32'd0);
            chk("abort.cyc", -1, 32'(cyc), 32'd15);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("regrant.cyc", 0, 32'(cyc), 32'd0);
        chk("regrant.spi", 0, 32'(spi_en), 32'd1);
        chk("regrant.ready", 0, 32'(spi_ready), 32'd0);
        @(posedge clk); #1;
        chk("regrant.spi", 1, 32'(spi_en), 32'd1);
        chk("regrant.ready", 1, 32'(spi_ready), 32'd1);
        valid = 1'b0;
        @(posedge clk); #1;
        chk("regrant.spi", 2, 32'(spi_en), 32'd0);
        chk("regrant.ready", 2, 32'(spi_ready), 32'd0);
        chk("regrant.vram0", 2, 32'(vram0), 32'd1);

        // 18-cycle frame: CPU slot 12..17, strobe at 17, then wrap
        rst6 = 1'b0;
        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            if (i < 16)
                chk("f18.cyc", i, 32'(cyc6), i);
            chk("f18.cpu", i, 32'({cpu_en6, cpu_clk6, cpu_be6}),
                (i >= 12) ? 32'd7 : 32'd0);
            chk("f18.setup", i, 32'(setup6),
                (i < 12) ? 32'(i % 2 == 0) : 32'(i == 12));
            chk("f18.strobe", i, 32'(strobe6),
                (i < 12) ? 32'(i % 2 == 1) : 32'(i == 17));
        end
        @(posedge clk); #1;
        chk("f18.wrap_cyc", 0, 32'(cyc6), 32'd0);
        chk("f18.wrap_setup", 0, 32'(setup6), 32'd1);
        chk("f18.wrap_cpu", 0, 32'(cpu_en6), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
